// File: rtl/mc_ctrl_hs_if.sv
// Controller <-> datapath/memory bundle for mc_ctrl_hs: decode inputs in,
// memory strobes and datapath enables out.
`timescale 1ns/1ps
interface mc_ctrl_hs_if;
  logic [3:0] opcode;
  logic       flag_z;
  logic       mem_ready;
  logic       mem_rd;
  logic       mem_wr;
  logic       mem_addr_src;
  logic       ld_IR;
  logic       ld_TR;
  logic       ld_DI;
  logic       ld_PC;
  logic       pc_src_jump;
  logic       rf_we;
  logic [1:0] rf_src;
  logic [1:0] alu_op;
  logic       alu_src_mem;
  logic       ld_CZN;
  logic       bus_err;
  logic [3:0] state;

  modport master (
    input  opcode, flag_z, mem_ready,
    output mem_rd, mem_wr, mem_addr_src, ld_IR, ld_TR, ld_DI, ld_PC,
           pc_src_jump, rf_we, rf_src, alu_op, alu_src_mem, ld_CZN,
           bus_err, state
  );

  modport slave (
    output opcode, flag_z, mem_ready,
    input  mem_rd, mem_wr, mem_addr_src, ld_IR, ld_TR, ld_DI, ld_PC,
           pc_src_jump, rf_we, rf_src, alu_op, alu_src_mem, ld_CZN,
           bus_err, state
  );
endinterface

// File: rtl/mc_ctrl_hs.sv
// Multi-cycle controller for the 8-bit accumulator datapath with a
// variable-latency memory handshake, wait timeout and sticky bus-error halt.
`timescale 1ns/1ps
module mc_ctrl_hs #(
  parameter int unsigned WAIT_MAX = 8,
  parameter bit          COND_JMP = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mc_ctrl_hs_if.master  bus
);
  localparam int unsigned CW = 8;
  localparam int unsigned SW = 4;

  typedef enum logic [SW-1:0] {
    S_IF  = 4'd0, S_DEC = 4'd1, S_LDI = 4'd2, S_MVR = 4'd3, S_RT  = 4'd4,
    S_AF  = 4'd5, S_MA  = 4'd6, S_MW  = 4'd7, S_JMP = 4'd8, S_ERR = 4'd9
  } state_t;

  state_t        st, st_nxt;
  logic [CW-1:0] wcnt, wcnt_nxt;

  logic [3:0] op;
  logic       is_ldi, is_lda, is_sta, is_ana, is_jmp, is_mvr, is_reg;
  logic       timeout, taken;

  logic       c_mem_rd, c_mem_wr, c_mem_addr_src;
  logic       c_ld_ir, c_ld_tr, c_ld_di, c_ld_pc, c_pc_src_jump;
  logic       c_rf_we, c_alu_src_mem, c_ld_czn, c_bus_err;
  logic [1:0] c_rf_src, c_alu_op;

  assign op      = bus.opcode;
  assign is_ldi  = (op[3:1] == 3'b000);
  assign is_lda  = (op[3:1] == 3'b001);
  assign is_sta  = (op[3:1] == 3'b010);
  assign is_ana  = (op[3:1] == 3'b100);
  assign is_jmp  = (op[3:1] == 3'b101);
  assign is_mvr  = (op == 4'b1100);
  assign is_reg  = (op[3:2] == 2'b11) && !is_mvr;
  assign timeout = (wcnt == CW'(WAIT_MAX));
  // Opcode 1010 always jumps; 1011 is conditional on Z only when COND_JMP is set.
  assign taken   = !COND_JMP || !op[0] || bus.flag_z;

  // State and wait-counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= S_IF;
      wcnt <= '0;
    end else begin
      st   <= st_nxt;
      wcnt <= wcnt_nxt;
    end
  end

  // Next state and control decode; wait counter holds only while a memory access stalls
  always_comb begin
    st_nxt         = st;
    wcnt_nxt       = '0;
    c_mem_rd       = 1'b0;
    c_mem_wr       = 1'b0;
    c_mem_addr_src = 1'b0;
    c_ld_ir        = 1'b0;
    c_ld_tr        = 1'b0;
    c_ld_di        = 1'b0;
    c_ld_pc        = 1'b0;
    c_pc_src_jump  = 1'b0;
    c_rf_we        = 1'b0;
    c_rf_src       = 2'b00;
    c_alu_op       = 2'b00;
    c_alu_src_mem  = 1'b0;
    c_ld_czn       = 1'b0;
    c_bus_err      = 1'b0;
    case (st)
      S_IF: begin
        c_mem_rd = 1'b1;
        if (bus.mem_ready) begin
          c_ld_ir = 1'b1;
          c_ld_pc = 1'b1;
          st_nxt  = S_DEC;
        end else if (timeout) st_nxt = S_ERR;
        else wcnt_nxt = wcnt + CW'(1);
      end
      S_DEC: begin
        if (is_ldi)      st_nxt = S_LDI;
        else if (is_mvr) st_nxt = S_MVR;
        else if (is_reg) st_nxt = S_RT;
        else             st_nxt = S_AF;
      end
      S_LDI: begin
        c_rf_we  = 1'b1;
        c_rf_src = 2'b10;
        st_nxt   = S_IF;
      end
      S_MVR: begin
        c_rf_we  = 1'b1;
        c_rf_src = 2'b11;
        c_ld_czn = 1'b1;
        c_alu_op = 2'b11;
        st_nxt   = S_IF;
      end
      S_RT: begin
        c_rf_we  = 1'b1;
        c_ld_czn = 1'b1;
        case (op[1:0])
          2'b10:   c_alu_op = 2'b01;
          2'b11:   c_alu_op = 2'b10;
          default: c_alu_op = 2'b00;
        endcase
        st_nxt = S_IF;
      end
      S_AF: begin
        c_mem_rd = 1'b1;
        if (bus.mem_ready) begin
          c_ld_tr = 1'b1;
          c_ld_pc = 1'b1;
          st_nxt  = is_jmp ? S_JMP : S_MA;
        end else if (timeout) st_nxt = S_ERR;
        else wcnt_nxt = wcnt + CW'(1);
      end
      S_MA: begin
        c_mem_addr_src = 1'b1;
        c_mem_wr       = is_sta;
        c_mem_rd       = !is_sta;
        if (bus.mem_ready) begin
          c_ld_di = !is_sta;
          st_nxt  = is_sta ? S_IF : S_MW;
        end else if (timeout) st_nxt = S_ERR;
        else wcnt_nxt = wcnt + CW'(1);
      end
      S_MW: begin
        c_rf_we = 1'b1;
        if (is_lda) c_rf_src = 2'b01;
        else begin
          c_alu_src_mem = 1'b1;
          c_alu_op      = is_ana ? 2'b01 : 2'b00;
          c_ld_czn      = 1'b1;
        end
        st_nxt = S_IF;
      end
      S_JMP: begin
        c_pc_src_jump = 1'b1;
        c_ld_pc       = taken;
        st_nxt        = S_IF;
      end
      S_ERR:   c_bus_err = 1'b1;
      default: st_nxt = S_ERR;
    endcase
  end

  // Reset forces every output low, aborting any pending access without a load pulse
  assign bus.mem_rd       = c_mem_rd & ~rst;
  assign bus.mem_wr       = c_mem_wr & ~rst;
  assign bus.mem_addr_src = c_mem_addr_src & ~rst;
  assign bus.ld_IR        = c_ld_ir & ~rst;
  assign bus.ld_TR        = c_ld_tr & ~rst;
  assign bus.ld_DI        = c_ld_di & ~rst;
  assign bus.ld_PC        = c_ld_pc & ~rst;
  assign bus.pc_src_jump  = c_pc_src_jump & ~rst;
  assign bus.rf_we        = c_rf_we & ~rst;
  assign bus.rf_src       = rst ? 2'b00 : c_rf_src;
  assign bus.alu_op       = rst ? 2'b00 : c_alu_op;
  assign bus.alu_src_mem  = c_alu_src_mem & ~rst;
  assign bus.ld_CZN       = c_ld_czn & ~rst;
  assign bus.bus_err      = c_bus_err & ~rst;
  assign bus.state        = rst ? 4'h0 : SW'(st);
endmodule
